// File: rtl/sel_pkg.sv
// Shared constants and state type for the register-file select encoder.
package sel_pkg;

    localparam int unsigned SEL_W  = 4;
    localparam int unsigned IR_W   = 32;
    localparam int unsigned RA_LSB = 23;
    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RC_LSB = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Binary index to one-hot decoder; every index value maps to a valid bit.
module onehot_dec #(
    parameter int unsigned SEL_W = 4
) (
    input  logic [SEL_W-1:0]      idx,
    output logic [2**SEL_W-1:0]   onehot
);

    // Set exactly the bit addressed by idx.
    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/select_encode_seq.sv
// Registered register-file select encoder with a self-timed scan sweep.
module select_encode_seq
    import sel_pkg::*;
#(
    parameter int unsigned SEL_W  = sel_pkg::SEL_W,
    parameter int unsigned IR_W   = sel_pkg::IR_W,
    parameter int unsigned RA_LSB = sel_pkg::RA_LSB,
    parameter int unsigned RB_LSB = sel_pkg::RB_LSB,
    parameter int unsigned RC_LSB = sel_pkg::RC_LSB
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [IR_W-1:0]       ir_in,
    input  logic                  ir_load,
    input  logic                  gra,
    input  logic                  grb,
    input  logic                  grc,
    input  logic                  rin,
    input  logic                  rout,
    input  logic                  baout,
    input  logic                  scan_start,
    output logic [2**SEL_W-1:0]   rin_onehot,
    output logic [2**SEL_W-1:0]   rout_onehot,
    output logic                  scan_busy,
    output logic                  scan_done
);

    localparam int unsigned NREG = 2**SEL_W;

    logic [IR_W-1:0]  ir_q;
    state_t           state;
    logic [SEL_W-1:0] cnt;

    logic [SEL_W-1:0] sel;
    logic             any_g;
    logic [SEL_W-1:0] scan_idx;
    logic [NREG-1:0]  sel_hot;
    logic [NREG-1:0]  scan_hot;
    logic             rin_hit;
    logic             rout_hit;
    logic             unused_ir_bits;

    // Only the three fields of ir_q are decoded; fold the rest into a sink.
    assign unused_ir_bits = ^ir_q;

    // Field select with gra > grb > grc priority, always from the held ir_q.
    always_comb begin
        sel   = '0;
        any_g = gra | grb | grc;
        if (gra)
            sel = ir_q[RA_LSB +: SEL_W];
        else if (grb)
            sel = ir_q[RB_LSB +: SEL_W];
        else if (grc)
            sel = ir_q[RC_LSB +: SEL_W];
    end

    // Scan index: 0 on scan entry from IDLE, next register while sweeping.
    always_comb begin
        scan_idx = '0;
        if (state == SCAN)
            scan_idx = cnt + 1'b1;
    end

    // baout drives like rout but never enables register 0.
    always_comb begin
        rin_hit  = rin & any_g;
        rout_hit = (rout | baout) & any_g & ~(baout & (sel == '0));
    end

    onehot_dec #(.SEL_W(SEL_W)) u_sel_dec (
        .idx    (sel),
        .onehot (sel_hot)
    );

    onehot_dec #(.SEL_W(SEL_W)) u_scan_dec (
        .idx    (scan_idx),
        .onehot (scan_hot)
    );

    // IR latch, scan sequencer and registered output enables.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            ir_q        <= '0;
            state       <= IDLE;
            cnt         <= '0;
            rin_onehot  <= '0;
            rout_onehot <= '0;
            scan_busy   <= 1'b0;
            scan_done   <= 1'b0;
        end else begin
            if (ir_load)
                ir_q <= ir_in;

            unique case (state)
                IDLE: begin
                    scan_done <= 1'b0;
                    if (scan_start) begin
                        state       <= SCAN;
                        cnt         <= '0;
                        rin_onehot  <= '0;
                        rout_onehot <= scan_hot;
                        scan_busy   <= 1'b1;
                    end else begin
                        rin_onehot  <= rin_hit  ? sel_hot : '0;
                        rout_onehot <= rout_hit ? sel_hot : '0;
                        scan_busy   <= 1'b0;
                    end
                end
                SCAN: begin
                    rin_onehot <= '0;
                    // Exit at the last index so cnt never wraps.
                    if (cnt == SEL_W'(NREG - 1)) begin
                        state       <= DONE;
                        cnt         <= '0;
                        rout_onehot <= '0;
                        scan_busy   <= 1'b0;
                        scan_done   <= 1'b1;
                    end else begin
                        cnt         <= cnt + 1'b1;
                        rout_onehot <= scan_hot;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    rin_onehot  <= '0;
                    rout_onehot <= '0;
                    scan_busy   <= 1'b0;
                    scan_done   <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    rin_onehot  <= '0;
                    rout_onehot <= '0;
                    scan_busy   <= 1'b0;
                    scan_done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_select_encode_seq.sv
// Scoreboard bench for select_encode_seq: decode, priority, same-edge load, scan, reset.
module tb_select_encode_seq;

    typedef logic [33:0] obs_t;

    typedef struct {
        logic        ld;
        logic [31:0] ir;
        logic        a, b, c, ri, ro, ba;
        logic [15:0] erin, erout;
        string       nm;
    } vec_t;

    logic        clock = 1'b0;
    logic        clear_n;
    logic [31:0] ir_in;
    logic        ir_load, gra, grb, grc, rin, rout, baout, scan_start;
    logic [15:0] rin_onehot, rout_onehot;
    logic        scan_busy, scan_done;

    obs_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clock = ~clock;

    select_encode_seq #(
        .SEL_W (4),
        .IR_W  (32),
        .RA_LSB(23),
        .RB_LSB(19),
        .RC_LSB(15)
    ) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .ir_in      (ir_in),
        .ir_load    (ir_load),
        .gra        (gra),
        .grb        (grb),
        .grc        (grc),
        .rin        (rin),
        .rout       (rout),
        .baout      (baout),
        .scan_start (scan_start),
        .rin_onehot (rin_onehot),
        .rout_onehot(rout_onehot),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done)
    );

    function automatic obs_t pk(logic [15:0] r_in, logic [15:0] r_out, logic busy, logic done);
        return {r_in, r_out, busy, done};
    endfunction

    function automatic logic [15:0] oh(int unsigned i);
        logic [15:0] one;
        one = 16'h0001;
        return one << i;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ir_load = 0; gra = 0; grb = 0; grc = 0;
        rin = 0; rout = 0; baout = 0; scan_start = 0;
    endtask

    task automatic apply(input vec_t v);
        ir_load = v.ld; ir_in = v.ir;
        gra = v.a; grb = v.b; grc = v.c;
        rin = v.ri; rout = v.ro; baout = v.ba;
        scan_start = 0;
    endtask

    task automatic test_reset();
        obs_t e, g;
        clear_n = 0;
        ir_in = $urandom; ir_load = 1; gra = 1; grb = 1; grc = 1;
        rin = 1; rout = 1; baout = 0; scan_start = 1;
        #1;
        exp_q.push_back(pk('0, '0, 0, 0));
        e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
        n_checks++;
        if (g !== e) $display("FAIL reset_hold got=%h exp=%h", g, e); else n_pass++;

        exp_q.push_back(pk('0, '0, 0, 0));
        step();
        e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
        n_checks++;
        if (g !== e) $display("FAIL reset_edge got=%h exp=%h", g, e); else n_pass++;

        idle_inputs();
        #2 clear_n = 1;
        exp_q.push_back(pk('0, '0, 0, 0));
        step();
        e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
        n_checks++;
        if (g !== e) $display("FAIL reset_release got=%h exp=%h", g, e); else n_pass++;

        gra = 1; rin = 1;
        exp_q.push_back(pk(oh(0), '0, 0, 0));
        step();
        e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
        n_checks++;
        if (g !== e) $display("FAIL reset_ir_zero got=%h exp=%h", g, e); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_field_select();
        vec_t v[4];
        obs_t e, g;
        v[0] = '{1, 32'h029E0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, "fs_load"};
        v[1] = '{0, 32'h0,        1, 0, 0, 1, 0, 0, 16'h0020, 16'h0000, "fs_ra_rin"};
        v[2] = '{0, 32'h0,        0, 1, 0, 0, 1, 0, 16'h0000, 16'h0008, "fs_rb_rout"};
        v[3] = '{0, 32'h0,        0, 0, 1, 0, 1, 0, 16'h0000, 16'h1000, "fs_rc_rout"};
        foreach (v[i]) begin
            apply(v[i]);
            exp_q.push_back(pk(v[i].erin, v[i].erout, 0, 0));
            step();
            e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
            n_checks++;
            if (g !== e) $display("FAIL %s got=%h exp=%h", v[i].nm, g, e); else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        vec_t v[8];
        obs_t e, g;
        v[0] = '{0, 32'h0, 1, 0, 1, 0, 1, 0, 16'h0000, 16'h0020, "pri_ra_over_rc"};
        v[1] = '{0, 32'h0, 1, 1, 0, 1, 0, 0, 16'h0020, 16'h0000, "pri_ra_over_rb"};
        v[2] = '{0, 32'h0, 0, 1, 0, 0, 0, 1, 16'h0000, 16'h0008, "baout_nonzero"};
        v[3] = '{1, 32'h0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, "pri_load_zero"};
        v[4] = '{0, 32'h0, 1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, "baout_zero_supp"};
        v[5] = '{0, 32'h0, 1, 0, 0, 0, 1, 0, 16'h0000, 16'h0001, "rout_zero"};
        v[6] = '{0, 32'h0, 0, 1, 0, 1, 1, 0, 16'h0001, 16'h0001, "rin_rout_both"};
        v[7] = '{0, 32'h0, 0, 0, 0, 1, 1, 1, 16'h0000, 16'h0000, "no_strobe"};
        foreach (v[i]) begin
            apply(v[i]);
            exp_q.push_back(pk(v[i].erin, v[i].erout, 0, 0));
            step();
            e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
            n_checks++;
            if (g !== e) $display("FAIL %s got=%h exp=%h", v[i].nm, g, e); else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_same_edge();
        vec_t v[3];
        obs_t e, g;
        v[0] = '{1, 32'h029E0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, "se_preload"};
        v[1] = '{1, 32'h04800000, 1, 0, 0, 1, 0, 0, 16'h0020, 16'h0000, "se_old_ir"};
        v[2] = '{0, 32'h0,        1, 0, 0, 1, 0, 0, 16'h0200, 16'h0000, "se_new_ir"};
        foreach (v[i]) begin
            apply(v[i]);
            exp_q.push_back(pk(v[i].erin, v[i].erout, 0, 0));
            step();
            e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
            n_checks++;
            if (g !== e) $display("FAIL %s got=%h exp=%h", v[i].nm, g, e); else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_scan();
        obs_t e, g;
        scan_start = 1;
        exp_q.push_back(pk('0, oh(0), 1, 0));
        step();
        e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
        n_checks++;
        if (g !== e) $display("FAIL scan_entry got=%h exp=%h", g, e); else n_pass++;

        // Strobes and a second start mid-sweep must all be ignored.
        for (int unsigned i = 1; i < 16; i++) begin
            gra = 1; rin = 1; rout = 1; baout = 1; ir_load = 1; ir_in = $urandom;
            scan_start = (i == 5);
            exp_q.push_back(pk('0, oh(i), 1, 0));
            step();
            e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
            n_checks++;
            if (g !== e) $display("FAIL scan_walk_%0d got=%h exp=%h", i, g, e); else n_pass++;
        end
        scan_start = 0;

        exp_q.push_back(pk('0, '0, 0, 1));
        step();
        e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
        n_checks++;
        if (g !== e) $display("FAIL scan_done_pulse got=%h exp=%h", g, e); else n_pass++;

        scan_start = 1;
        exp_q.push_back(pk('0, '0, 0, 0));
        step();
        e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
        n_checks++;
        if (g !== e) $display("FAIL scan_done_clear got=%h exp=%h", g, e); else n_pass++;

        idle_inputs();
        exp_q.push_back(pk('0, '0, 0, 0));
        step();
        e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
        n_checks++;
        if (g !== e) $display("FAIL scan_no_restart got=%h exp=%h", g, e); else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        obs_t e, g;
        idle_inputs();
        scan_start = 1;
        for (int unsigned i = 0; i <= 6; i++) begin
            exp_q.push_back(pk('0, oh(i), 1, 0));
            step();
            scan_start = 0;
            e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
            n_checks++;
            if (g !== e) $display("FAIL mid_walk_%0d got=%h exp=%h", i, g, e); else n_pass++;
        end

        #2 clear_n = 0;
        #1;
        exp_q.push_back(pk('0, '0, 0, 0));
        e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
        n_checks++;
        if (g !== e) $display("FAIL mid_async_clear got=%h exp=%h", g, e); else n_pass++;

        exp_q.push_back(pk('0, '0, 0, 0));
        step();
        e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
        n_checks++;
        if (g !== e) $display("FAIL mid_clear_hold got=%h exp=%h", g, e); else n_pass++;

        #2 clear_n = 1;
        for (int unsigned i = 0; i < 2; i++) begin
            exp_q.push_back(pk('0, '0, 0, 0));
            step();
            e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
            n_checks++;
            if (g !== e) $display("FAIL mid_no_done_%0d got=%h exp=%h", i, g, e); else n_pass++;
        end

        scan_start = 1;
        for (int unsigned i = 0; i < 16; i++) begin
            exp_q.push_back(pk('0, oh(i), 1, 0));
            step();
            scan_start = 0;
            e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
            n_checks++;
            if (g !== e) $display("FAIL rescan_%0d got=%h exp=%h", i, g, e); else n_pass++;
        end
        exp_q.push_back(pk('0, '0, 0, 1));
        exp_q.push_back(pk('0, '0, 0, 0));
        for (int unsigned i = 0; i < 2; i++) begin
            step();
            e = exp_q.pop_front(); g = {rin_onehot, rout_onehot, scan_busy, scan_done};
            n_checks++;
            if (g !== e) $display("FAIL rescan_end_%0d got=%h exp=%h", i, g, e); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_field_select();
        test_priority();
        test_same_edge();
        test_scan();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
